// File: rtl/fifo_flex.sv
// Parametrised synchronous FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags, flush and selectable FWFT read.
module fifo_flex #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int AF_LEVEL   = 12,
  parameter int AE_LEVEL   = 4,
  parameter int FWFT       = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] w_data,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_valid,
  output logic                  empty,
  output logic                  full,
  output logic                  almost_empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_CNT   = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_CNT   = (ADDR_WIDTH + 1)'(AE_LEVEL);

  if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin : g_bad_af
    $error("fifo_flex: AF_LEVEL=%0d outside 1..%0d", AF_LEVEL, DEPTH);
  end
  if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin : g_bad_ae
    $error("fifo_flex: AE_LEVEL=%0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
  end

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  rd_acc;
  logic                  wr_acc;

  assign empty        = (count == '0);
  assign full         = (count == FULL_CNT);
  assign almost_empty = (count <= AE_CNT);
  assign almost_full  = (count >= AF_CNT);

  // A read on a full FIFO frees the slot the simultaneous write lands in.
  assign rd_acc = rd & ~empty;
  assign wr_acc = wr & (~full | rd_acc);

  always_ff @(posedge clk) begin
    if (reset && !clr && wr_acc) begin
      mem[w_ptr] <= w_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (clr) begin
      w_ptr     <= '0;
      r_ptr     <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) w_ptr <= w_ptr + ADDR_WIDTH'(1);
      if (rd_acc) r_ptr <= r_ptr + ADDR_WIDTH'(1);
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + (ADDR_WIDTH + 1)'(1);
        2'b01:   count <= count - (ADDR_WIDTH + 1)'(1);
        default: count <= count;
      endcase
      if (wr && !wr_acc) overflow  <= 1'b1;
      if (rd && empty)   underflow <= 1'b1;
    end
  end

  if (FWFT == 0) begin : g_reg_read
    // Flush drops the valid pulse but keeps the last word on r_data.
    always_ff @(posedge clk) begin
      if (!reset) begin
        r_data  <= '0;
        r_valid <= 1'b0;
      end else if (clr) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= rd_acc;
        if (rd_acc) r_data <= mem[r_ptr];
      end
    end
  end else begin : g_fwft_read
    assign r_data  = mem[r_ptr];
    assign r_valid = ~empty;
  end

endmodule

// File: tb/tb_fifo_flex.sv
// Bench for fifo_flex: one registered-read and one FWFT instance share stimulus
// and are compared every cycle against a queue-based model of the FIFO.
module tb_fifo_flex;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;
  localparam int AE    = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          clr = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] w_data = '0;

  logic [DW-1:0] r_data0, r_data1;
  logic          r_valid0, r_valid1, empty0, empty1, full0, full1;
  logic          ae0, ae1, af0, af1, ovf0, ovf1, unf0, unf1;
  logic [AW:0]   count0, count1;

  fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)) dut0 (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data0), .r_valid(r_valid0), .empty(empty0), .full(full0),
    .almost_empty(ae0), .almost_full(af0), .count(count0),
    .overflow(ovf0), .underflow(unf0)
  );

  fifo_flex #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)) dut1 (
    .clk(clk), .reset(reset), .clr(clr), .wr(wr), .w_data(w_data), .rd(rd),
    .r_data(r_data1), .r_valid(r_valid1), .empty(empty1), .full(full1),
    .almost_empty(ae1), .almost_full(af1), .count(count1),
    .overflow(ovf1), .underflow(unf1)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned failures = 0;
  int unsigned printed = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (printed < 40) begin
        printed++;
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
    end
  endfunction

  // Reference model: contents as a queue, sticky flags, registered read word.
  logic [DW-1:0] q[$];
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            m_rv = 0;
  logic [DW-1:0] m_rdata = '0;
  bit            mvalid = 0;

  initial begin
    bit rd_ok, wr_ok;
    int n;
    forever begin
      @(posedge clk);
      if (!reset) begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0; m_rdata = '0;
        mvalid = 1;
      end else if (clr) begin
        q.delete();
        m_ovf = 0; m_unf = 0; m_rv = 0;
      end else begin
        n = q.size();
        rd_ok = rd && (n > 0);
        wr_ok = wr && ((n < DEPTH) || rd_ok);
        if (wr && !wr_ok) m_ovf = 1;
        if (rd && n == 0) m_unf = 1;
        m_rv = rd_ok;
        if (rd_ok) m_rdata = q.pop_front();
        if (wr_ok) q.push_back(w_data);
      end
    end
  end

  initial begin
    int n;
    forever begin
      @(negedge clk);
      if (mvalid) begin
        n = q.size();
        chk("count0", 32'(count0), 32'(n));
        chk("empty0", 32'(empty0), 32'(n == 0));
        chk("full0", 32'(full0), 32'(n == DEPTH));
        chk("almost_empty0", 32'(ae0), 32'(n <= AE));
        chk("almost_full0", 32'(af0), 32'(n >= AF));
        chk("overflow0", 32'(ovf0), 32'(m_ovf));
        chk("underflow0", 32'(unf0), 32'(m_unf));
        chk("r_valid0", 32'(r_valid0), 32'(m_rv));
        chk("r_data0", 32'(r_data0), 32'(m_rdata));
        chk("count1", 32'(count1), 32'(n));
        chk("empty1", 32'(empty1), 32'(n == 0));
        chk("full1", 32'(full1), 32'(n == DEPTH));
        chk("almost_empty1", 32'(ae1), 32'(n <= AE));
        chk("almost_full1", 32'(af1), 32'(n >= AF));
        chk("overflow1", 32'(ovf1), 32'(m_ovf));
        chk("underflow1", 32'(unf1), 32'(m_unf));
        chk("r_valid1", 32'(r_valid1), 32'(n != 0));
        if (n != 0) chk("r_data1_head", 32'(r_data1), 32'(q[0]));
      end
    end
  end

  task automatic drive(input logic rs, input logic c, input logic w, input logic [DW-1:0] d,
                       input logic r);
    @(negedge clk);
    reset = rs; clr = c; wr = w; w_data = d; rd = r;
  endtask

  task automatic idle();
    drive(1'b1, 1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    bit w, r, c, rs;
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    chk("rst_count", 32'(count0), 0);
    chk("rst_empty", 32'(empty0), 1);
    chk("rst_almost_empty", 32'(ae0), 1);
    chk("rst_full", 32'(full0), 0);
    chk("rst_almost_full", 32'(af0), 0);
    chk("rst_overflow", 32'(ovf0), 0);
    chk("rst_underflow", 32'(unf0), 0);
    chk("rst_r_valid", 32'(r_valid0), 0);
    chk("rst_r_data", 32'(r_data0), 0);

    for (int i = 1; i <= 16; i++) drive(1'b1, 1'b0, 1'b1, DW'(i), 1'b0);
    idle();
    chk("fill_count", 32'(count0), 16);
    chk("fill_full", 32'(full0), 1);
    chk("fill_almost_full", 32'(af0), 1);

    drive(1'b1, 1'b0, 1'b1, 8'h11, 1'b0);
    idle();
    chk("ovf_flag", 32'(ovf0), 1);
    chk("ovf_count", 32'(count0), 16);

    drive(1'b1, 1'b0, 1'b1, 8'hAA, 1'b1);
    idle();
    chk("full_rdwr_count", 32'(count0), 16);
    chk("full_rdwr_data", 32'(r_data0), 8'h01);
    chk("full_rdwr_ovf_sticky", 32'(ovf0), 1);

    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("drain_last_data", 32'(r_data0), 8'hAA);
    chk("drain_empty", 32'(empty0), 1);

    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("unf_flag", 32'(unf0), 1);
    chk("unf_count", 32'(count0), 0);

    drive(1'b1, 1'b1, 1'b1, 8'h33, 1'b1);
    idle();
    chk("clr_ovf", 32'(ovf0), 0);
    chk("clr_unf", 32'(unf0), 0);
    chk("clr_count", 32'(count0), 0);
    chk("clr_keeps_r_data", 32'(r_data0), 8'hAA);

    drive(1'b1, 1'b0, 1'b1, 8'h44, 1'b1);
    idle();
    chk("empty_rdwr_count", 32'(count0), 1);
    chk("empty_rdwr_unf", 32'(unf0), 1);

    drive(1'b1, 1'b1, 1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b1, DW'(8'h60 + i), 1'b0);
    for (int i = 0; i < 40; i++) drive(1'b1, 1'b0, 1'b1, DW'(8'h80 + i), 1'b1);
    idle();
    chk("wrap_count", 32'(count0), 3);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("wrap_tail_data", 32'(r_data0), 8'h80 + 39);

    for (int i = 0; i < 3000; i++) begin
      w  = ($urandom_range(99) < (((i / 120) % 2 == 0) ? 75 : 25));
      r  = ($urandom_range(99) < (((i / 120) % 2 == 0) ? 25 : 75));
      c  = ($urandom_range(199) == 0);
      rs = ($urandom_range(499) != 0);
      drive(rs, c, w, DW'($urandom), r);
    end

    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    drive(1'b1, 1'b0, 1'b1, 8'h5C, 1'b0);
    idle();
    chk("fwft_first_data", 32'(r_data1), 8'h5C);
    chk("fwft_first_valid", 32'(r_valid1), 1);
    chk("fwft_first_empty", 32'(empty1), 0);
    drive(1'b1, 1'b0, 1'b1, 8'h77, 1'b0);
    drive(1'b1, 1'b0, 1'b0, '0, 1'b1);
    idle();
    chk("fwft_pop_data", 32'(r_data1), 8'h77);
    chk("fwft_pop_count", 32'(count1), 1);
    drive(1'b1, 1'b0, 1'b1, 8'h88, 1'b0);
    drive(1'b0, 1'b0, 1'b0, '0, 1'b0);
    idle();
    chk("fwft_rst_empty", 32'(empty1), 1);
    chk("fwft_rst_valid", 32'(r_valid1), 0);
    chk("fwft_rst_count", 32'(count1), 0);

    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
